// File: rtl/prime_pkg.sv
// Shared constants for the prime checker sweep sequencer.
// W         : data width of the checker operand.
// TIMEOUT_D : default cycle budget for one checker verdict.
// TW_D      : default timeout counter width (2**TW_D > TIMEOUT_D).
// state_t   : sweep FSM state encoding.
// RES_PRIME : checker verdict value meaning "prime".
package prime_pkg;

    localparam int unsigned W         = 16;
    localparam int unsigned TIMEOUT_D = 4096;
    localparam int unsigned TW_D      = 13;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic RES_PRIME = 1'b0;

endpackage

// File: rtl/prime_sweep.sv
// Sequencer that sweeps an inclusive range [lo, hi] through the prime checker
// and streams out every prime found on a valid/ready interface.
// Ports:
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   start, lo, hi     : sweep request and inclusive bounds (sampled in IDLE/DONE)
//   sw, go            : operand and one-cycle start pulse to the checker
//   res, stp          : checker verdict (0 = prime) and done flag
//   prime_val/vld/rdy : prime output stream
//   count             : primes emitted in this sweep (saturating)
//   busy, done, err   : sweep status; err flags a checker timeout
// Requires 2**TW > TIMEOUT.
module prime_sweep #(
    parameter int unsigned W       = prime_pkg::W,
    parameter int unsigned TIMEOUT = prime_pkg::TIMEOUT_D,
    parameter int unsigned TW      = prime_pkg::TW_D
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] hi,
    output logic [W-1:0] sw,
    output logic         go,
    input  logic         res,
    input  logic         stp,
    output logic [W-1:0] prime_val,
    output logic         prime_vld,
    input  logic         prime_rdy,
    output logic [W-1:0] count,
    output logic         busy,
    output logic         done,
    output logic         err
);

    import prime_pkg::*;

    state_t        state, state_nxt;
    logic [W-1:0]  cur, cur_nxt;
    logic [W-1:0]  last, last_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic [W-1:0]  sw_nxt;
    logic [W-1:0]  pval_nxt;
    logic [W-1:0]  count_nxt;
    logic          err_nxt;

    // State and registered outputs; status flags follow the next state so
    // they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cur       <= '0;
            last      <= '0;
            tcnt      <= '0;
            sw        <= '0;
            go        <= 1'b0;
            prime_val <= '0;
            prime_vld <= 1'b0;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur       <= cur_nxt;
            last      <= last_nxt;
            tcnt      <= tcnt_nxt;
            sw        <= sw_nxt;
            go        <= (state_nxt == S_ISSUE);
            prime_val <= pval_nxt;
            prime_vld <= (state_nxt == S_EMIT);
            count     <= count_nxt;
            busy      <= (state_nxt == S_ISSUE) || (state_nxt == S_WAIT) ||
                         (state_nxt == S_EMIT);
            done      <= (state_nxt == S_DONE);
            err       <= err_nxt;
        end
    end

    // Next-state, range cursor and timeout logic.
    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        last_nxt  = last;
        tcnt_nxt  = tcnt;
        pval_nxt  = prime_val;
        count_nxt = count;
        err_nxt   = err;

        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    cur_nxt   = lo;
                    last_nxt  = hi;
                    count_nxt = '0;
                    err_nxt   = 1'b0;
                    state_nxt = (lo > hi) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                tcnt_nxt  = '0;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (stp) begin
                    if (res == RES_PRIME) begin
                        pval_nxt  = cur;
                        state_nxt = S_EMIT;
                    end else if (cur == last) begin
                        // End test precedes the increment so hi = all-ones never wraps.
                        state_nxt = S_DONE;
                    end else begin
                        cur_nxt   = cur + W'(1);
                        state_nxt = S_ISSUE;
                    end
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    tcnt_nxt = tcnt + TW'(1);
                end
            end
            S_EMIT: begin
                if (prime_rdy) begin
                    if (count != '1) begin
                        count_nxt = count + W'(1);
                    end
                    if (cur == last) begin
                        state_nxt = S_DONE;
                    end else begin
                        cur_nxt   = cur + W'(1);
                        state_nxt = S_ISSUE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // The operand is loaded on entry to ISSUE and held through WAIT.
        sw_nxt = sw;
        if (state_nxt == S_ISSUE) begin
            sw_nxt = cur_nxt;
        end
    end

endmodule

// File: tb/tb_prime_sweep.sv
// Bench for prime_sweep: a behavioural checker model with programmable
// latency answers each go, a scoreboard holds the expected primes and
// operands, and a negedge monitor compares the stream as it appears.
module tb_prime_sweep;

    localparam int unsigned W       = 16;
    localparam int unsigned TIMEOUT = 16;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [W-1:0] lo, hi, sw, prime_val, count;
    logic         go, res, stp, prime_vld, prime_rdy, busy, done, err;

    always #5 clk = ~clk;

    prime_sweep #(.W(W), .TIMEOUT(TIMEOUT), .TW(5)) dut (
        .clk(clk), .rst(rst), .start(start), .lo(lo), .hi(hi),
        .sw(sw), .go(go), .res(res), .stp(stp),
        .prime_val(prime_val), .prime_vld(prime_vld), .prime_rdy(prime_rdy),
        .count(count), .busy(busy), .done(done), .err(err)
    );

    int  n_vec = 0;
    int  n_err = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] sw_q[$];
    int  gos = 0;
    bit  saw_vld = 1'b0;
    time go_time = 0;
    time t_start = 0;

    int  lat = 3;
    bit  rand_lat = 1'b0;
    bit  hang = 1'b0;
    bit  force_np = 1'b0;
    int  rdy_mode = 0;

    function automatic bit is_prime(input int unsigned v);
        if (v < 2) return 1'b0;
        for (int unsigned d = 2; d * d <= v; d++)
            if (v % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string name, input longint act, input longint expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic fail_now(input string name, input longint act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got %0d expected nothing", name, act);
    endtask

    // Checker model: verdict appears a programmable number of cycles after go
    // and is held until the next go.
    int unsigned  pend_cnt;
    bit           pend;
    logic [W-1:0] opnd;
    always @(posedge clk) begin
        if (rst) begin
            stp  <= 1'b0;
            res  <= 1'b0;
            pend <= 1'b0;
        end else if (go) begin
            stp      <= 1'b0;
            pend     <= 1'b1;
            opnd     <= sw;
            pend_cnt <= rand_lat ? $urandom_range(1, 6) : lat;
        end else if (pend && !hang) begin
            if (pend_cnt <= 1) begin
                stp  <= 1'b1;
                res  <= force_np ? 1'b1 : ~is_prime(32'(opnd));
                pend <= 1'b0;
            end else begin
                pend_cnt <= pend_cnt - 1;
            end
        end
    end

    // Consumer ready: always, random, or stalled 10 cycles on each new valid.
    int stall_cnt = 0;
    bit vld_prev = 1'b0;
    initial begin
        prime_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: prime_rdy = 1'b1;
                1: prime_rdy = 1'($urandom_range(0, 1));
                default: begin
                    if (prime_vld && !vld_prev) stall_cnt = 10;
                    prime_rdy = (stall_cnt == 0);
                    if (stall_cnt > 0) stall_cnt--;
                end
            endcase
            vld_prev = prime_vld;
        end
    end

    // Monitor: operand per go, prime per handshake, stability while stalled.
    logic [W-1:0] held_val;
    bit           holding = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            holding = 1'b0;
        end else begin
            if (go) begin
                gos++;
                go_time = $time;
                if (sw_q.size() == 0) fail_now("extra_go", longint'(sw));
                else chk("go_sw", longint'(sw), longint'(sw_q.pop_front()));
            end
            if (prime_vld) saw_vld = 1'b1;
            if (holding) begin
                chk("hold_vld", longint'(prime_vld), 1);
                chk("hold_val", longint'(prime_val), longint'(held_val));
            end
            if (prime_vld && prime_rdy) begin
                if (exp_q.size() == 0) fail_now("extra_prime", longint'(prime_val));
                else chk("prime_val", longint'(prime_val), longint'(exp_q.pop_front()));
            end
            holding  = prime_vld && !prime_rdy;
            held_val = prime_val;
        end
    end

    task automatic start_sweep(input logic [W-1:0] l, input logic [W-1:0] h);
        @(posedge clk);
        #1;
        lo = l;
        hi = h;
        start = 1'b1;
        @(posedge clk);
        t_start = $time;
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output time t_done);
        int n = 0;
        t_done = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        if (!done) fail_now("done_timeout", n);
        else t_done = $time;
    endtask

    // Builds the expected operands/primes from the range rules, runs a sweep
    // and checks the final status.
    task automatic run(input logic [W-1:0] l, input logic [W-1:0] h,
                       input string tag, output time t_done);
        int exp_n, exp_gos;
        exp_q.delete();
        sw_q.delete();
        gos = 0;
        saw_vld = 1'b0;
        for (int unsigned v = 32'(l); v <= 32'(h); v++) begin
            sw_q.push_back(W'(v));
            if (hang) break;
            if (!force_np && is_prime(v)) exp_q.push_back(W'(v));
        end
        exp_n   = exp_q.size();
        exp_gos = sw_q.size();
        start_sweep(l, h);
        wait_done(5000, t_done);
        @(negedge clk);
        chk({tag, "_done"}, longint'(done), 1);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_count"}, longint'(count), exp_n);
        chk({tag, "_err"}, longint'(err), longint'(hang));
        chk({tag, "_gos"}, gos, exp_gos);
        chk({tag, "_left"}, exp_q.size(), 0);
    endtask

    initial begin
        time t_done;
        int  n;
        rst = 1'b1;
        start = 1'b0;
        lo = '0;
        hi = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sw", longint'(sw), 0);
        chk("rst_go", longint'(go), 0);
        chk("rst_pval", longint'(prime_val), 0);
        chk("rst_vld", longint'(prime_vld), 0);
        chk("rst_count", longint'(count), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_err", longint'(err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 3..30 with random checker latency
        rand_lat = 1'b1;
        rdy_mode = 0;
        run(16'd3, 16'd30, "r3_30", t_done);
        chk("r3_30_gos28", gos, 28);

        // empty range
        run(16'd20, 16'd10, "empty", t_done);
        chk("empty_lat", longint'((t_done - t_start) / 10 + 1), 1);
        chk("empty_novld", longint'(saw_vld), 0);

        // top of range, forced non-prime: exactly one go, no wrap
        force_np = 1'b1;
        run(16'hFFFF, 16'hFFFF, "top", t_done);
        repeat (20) @(negedge clk);
        chk("top_nowrap", gos, 1);
        force_np = 1'b0;

        // checker never answers
        hang = 1'b1;
        run(16'd40, 16'd50, "hang", t_done);
        chk("hang_wait", longint'((t_done - go_time) / 10 - 1), TIMEOUT);
        chk("hang_novld", longint'(saw_vld), 0);
        hang = 1'b0;

        // back-pressure
        rdy_mode = 2;
        run(16'd2, 16'd7, "stall", t_done);
        rdy_mode = 0;

        // reset in WAIT mid-sweep
        rand_lat = 1'b0;
        lat = 4;
        exp_q.delete();
        sw_q.delete();
        for (int unsigned v = 3; v <= 100; v++) begin
            sw_q.push_back(W'(v));
            if (is_prime(v)) exp_q.push_back(W'(v));
        end
        start_sweep(16'd3, 16'd100);
        n = 0;
        do begin @(negedge clk); n++; end while (count < 2 && n < 2000);
        chk("mid_progress", longint'(count >= 2), 1);
        n = 0;
        do begin @(negedge clk); n++; end while (!go && n < 200);
        chk("mid_go", longint'(go), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_go0", longint'(go), 0);
        chk("mid_vld0", longint'(prime_vld), 0);
        chk("mid_count0", longint'(count), 0);
        chk("mid_busy0", longint'(busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(16'd5, 16'd5, "after_rst", t_done);

        // random ranges, random latency and ready
        rand_lat = 1'b1;
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] l, h;
            l = W'($urandom_range(0, 300));
            h = (i == 7) ? l - W'(1) : l + W'($urandom_range(0, 30));
            run(l, h, "rand", t_done);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
